// File: rtl/clockmaster_pkg.sv
// Shared definitions for the clockmaster pulse generator and timestamper:
// FSM state encodings, default timebase and the Thunderbolt time record.
package clockmaster_pkg;

  localparam int unsigned c_CLKS_PER_1_US = 10;

  localparam logic [3:0] s_IDLE      = 4'd0;
  localparam logic [3:0] s_ARM       = 4'd1;
  localparam logic [3:0] s_WAIT_RISE = 4'd2;
  localparam logic [3:0] s_HIGH      = 4'd3;
  localparam logic [3:0] s_LOW       = 4'd4;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
  } thunder_time_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
module bit_synchronizer #(
  parameter int unsigned stages = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [stages-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= i_async;
      for (int unsigned i = 1; i < stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign o_sync = sync_q[stages-1];

endmodule

// File: rtl/pulse_timestamper.sv
// Measures an external pulse train: timestamps each rise against Thunderbolt
// time and reports high width and rise-to-rise period in microseconds.
module pulse_timestamper #(
  parameter int unsigned c_CLKS_PER_1_US = clockmaster_pkg::c_CLKS_PER_1_US,
  parameter int unsigned c_SYNC_STAGES   = 2,
  parameter int unsigned c_MEAS_BITS     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_pulse_in,
  input  logic        i_thunder_packet_dv,
  input  logic [15:0] i_thunder_year,
  input  logic [7:0]  i_thunder_month,
  input  logic [7:0]  i_thunder_day,
  input  logic [7:0]  i_thunder_hour,
  input  logic [7:0]  i_thunder_minutes,
  input  logic [7:0]  i_thunder_seconds,
  output logic [15:0] o_ts_year,
  output logic [7:0]  o_ts_month,
  output logic [7:0]  o_ts_day,
  output logic [7:0]  o_ts_hour,
  output logic [7:0]  o_ts_minutes,
  output logic [7:0]  o_ts_seconds,
  output logic [31:0] o_ts_us,
  output logic        o_ts_valid,
  output logic [32:0] o_width_us,
  output logic [32:0] o_period_us,
  output logic        o_pulse_dv,
  output logic        o_period_dv,
  output logic        o_overflow
);

  import clockmaster_pkg::*;

  localparam int unsigned c_PW = (c_CLKS_PER_1_US > 1) ? $clog2(c_CLKS_PER_1_US) : 1;
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(c_CLKS_PER_1_US - 1);
  localparam logic [c_PW-1:0] c_PRESC_ONE = c_PW'(1);

  // Input path
  logic sync_s;
  logic prev_q;
  logic rise_s;
  logic fall_s;

  bit_synchronizer #(
    .stages(c_SYNC_STAGES)
  ) u_pulse_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(i_pulse_in),
    .o_sync (sync_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) prev_q <= 1'b0;
    else       prev_q <= sync_s;
  end

  assign rise_s = sync_s & ~prev_q;
  assign fall_s = ~sync_s & prev_q;

  // Thunderbolt time shadow and microseconds-since-packet counter
  thunder_time_t     shadow_q, shadow_d;
  logic              time_seen_q, time_seen_d;
  logic [c_PW-1:0]   sub_presc_q, sub_presc_d;
  logic [31:0]       us_q, us_d;
  logic              sub_tick;

  assign sub_tick = (sub_presc_q == c_PRESC_MAX);

  always_comb begin
    shadow_d    = shadow_q;
    time_seen_d = time_seen_q;
    sub_presc_d = sub_tick ? '0 : sub_presc_q + c_PRESC_ONE;
    us_d        = (sub_tick && (us_q != '1)) ? us_q + 32'd1 : us_q;
    if (i_thunder_packet_dv) begin
      shadow_d.year    = i_thunder_year;
      shadow_d.month   = i_thunder_month;
      shadow_d.day     = i_thunder_day;
      shadow_d.hour    = i_thunder_hour;
      shadow_d.minutes = i_thunder_minutes;
      shadow_d.seconds = i_thunder_seconds;
      sub_presc_d      = '0;
      us_d             = '0;
      time_seen_d      = 1'b1;
    end
    if (!i_enable) begin
      time_seen_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_q    <= '0;
      time_seen_q <= 1'b0;
      sub_presc_q <= '0;
      us_q        <= '0;
    end else begin
      shadow_q    <= shadow_d;
      time_seen_q <= time_seen_d;
      sub_presc_q <= sub_presc_d;
      us_q        <= us_d;
    end
  end

  // Measurement FSM and counters
  logic [3:0]             state_q, state_d;
  logic [c_PW-1:0]        meas_presc_q, meas_presc_d;
  logic [c_MEAS_BITS-1:0] width_q, width_d;
  logic [c_MEAS_BITS-1:0] period_q, period_d;
  logic                   width_ovf_q, width_ovf_d;
  logic                   period_ovf_q, period_ovf_d;

  thunder_time_t          ts_q, ts_d;
  logic [31:0]            ts_us_q, ts_us_d;
  logic                   ts_valid_q, ts_valid_d;
  logic [32:0]            width_us_q, width_us_d;
  logic [32:0]            period_us_q, period_us_d;
  logic                   pulse_dv_q, pulse_dv_d;
  logic                   period_dv_q, period_dv_d;
  logic                   overflow_q, overflow_d;

  logic                   meas_tick;
  logic [c_PW-1:0]        meas_presc_next;
  logic                   width_sat, period_sat;
  logic [c_MEAS_BITS-1:0] width_inc, period_inc;
  logic                   width_ovf_inc, period_ovf_inc;
  logic                   capture_s;

  // *_inc include the current cycle, so a reported result covers every clock
  // from the capturing rise up to and including the detection cycle.
  assign meas_tick       = (meas_presc_q == c_PRESC_MAX);
  assign meas_presc_next = meas_tick ? '0 : meas_presc_q + c_PRESC_ONE;
  assign width_sat       = (width_q == '1);
  assign period_sat      = (period_q == '1);
  assign width_inc       = (meas_tick && !width_sat) ? width_q + c_MEAS_BITS'(1) : width_q;
  assign period_inc      = (meas_tick && !period_sat) ? period_q + c_MEAS_BITS'(1) : period_q;
  assign width_ovf_inc   = width_ovf_q | (meas_tick & width_sat);
  assign period_ovf_inc  = period_ovf_q | (meas_tick & period_sat);

  always_comb begin
    state_d      = state_q;
    meas_presc_d = meas_presc_q;
    width_d      = width_q;
    period_d     = period_q;
    width_ovf_d  = width_ovf_q;
    period_ovf_d = period_ovf_q;
    ts_d         = ts_q;
    ts_us_d      = ts_us_q;
    ts_valid_d   = ts_valid_q;
    width_us_d   = width_us_q;
    period_us_d  = period_us_q;
    overflow_d   = overflow_q;
    pulse_dv_d   = 1'b0;
    period_dv_d  = 1'b0;
    capture_s    = 1'b0;

    if (!i_enable) begin
      state_d      = s_IDLE;
      meas_presc_d = '0;
      width_d      = '0;
      period_d     = '0;
      width_ovf_d  = 1'b0;
      period_ovf_d = 1'b0;
    end else begin
      case (state_q)
        s_IDLE: state_d = s_ARM;
        s_ARM: begin
          if (!sync_s) state_d = s_WAIT_RISE;
        end
        s_WAIT_RISE: begin
          if (rise_s) begin
            capture_s = 1'b1;
            state_d   = s_HIGH;
          end
        end
        s_HIGH: begin
          meas_presc_d = meas_presc_next;
          width_d      = width_inc;
          width_ovf_d  = width_ovf_inc;
          period_d     = period_inc;
          period_ovf_d = period_ovf_inc;
          if (fall_s) begin
            width_us_d = 33'(width_inc);
            overflow_d = width_ovf_inc;
            pulse_dv_d = 1'b1;
            state_d    = s_LOW;
          end
        end
        s_LOW: begin
          meas_presc_d = meas_presc_next;
          period_d     = period_inc;
          period_ovf_d = period_ovf_inc;
          if (rise_s) begin
            period_us_d = 33'(period_inc);
            overflow_d  = period_ovf_inc;
            period_dv_d = 1'b1;
            capture_s   = 1'b1;
            state_d     = s_HIGH;
          end
        end
        default: state_d = s_IDLE;
      endcase

      // Registered shadow/us values give pre-update time when a packet lands on the rise.
      if (capture_s) begin
        ts_d         = shadow_q;
        ts_us_d      = us_q;
        ts_valid_d   = time_seen_q;
        meas_presc_d = '0;
        width_d      = '0;
        period_d     = '0;
        width_ovf_d  = 1'b0;
        period_ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= s_IDLE;
      meas_presc_q <= '0;
      width_q      <= '0;
      period_q     <= '0;
      width_ovf_q  <= 1'b0;
      period_ovf_q <= 1'b0;
      ts_q         <= '0;
      ts_us_q      <= '0;
      ts_valid_q   <= 1'b0;
      width_us_q   <= '0;
      period_us_q  <= '0;
      pulse_dv_q   <= 1'b0;
      period_dv_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      meas_presc_q <= meas_presc_d;
      width_q      <= width_d;
      period_q     <= period_d;
      width_ovf_q  <= width_ovf_d;
      period_ovf_q <= period_ovf_d;
      ts_q         <= ts_d;
      ts_us_q      <= ts_us_d;
      ts_valid_q   <= ts_valid_d;
      width_us_q   <= width_us_d;
      period_us_q  <= period_us_d;
      pulse_dv_q   <= pulse_dv_d;
      period_dv_q  <= period_dv_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_ts_year    = ts_q.year;
  assign o_ts_month   = ts_q.month;
  assign o_ts_day     = ts_q.day;
  assign o_ts_hour    = ts_q.hour;
  assign o_ts_minutes = ts_q.minutes;
  assign o_ts_seconds = ts_q.seconds;
  assign o_ts_us      = ts_us_q;
  assign o_ts_valid   = ts_valid_q;
  assign o_width_us   = width_us_q;
  assign o_period_us  = period_us_q;
  assign o_pulse_dv   = pulse_dv_q;
  assign o_period_dv  = period_dv_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_timestamper.sv
// Directed bench for pulse_timestamper: default build plus a short-counter build
// (1 clock per us, 4-bit measurement) used to reach saturation quickly.
module tb_pulse_timestamper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, pulse, dv, en2, pulse2;
  logic [15:0] yr;
  logic [7:0]  mo, dy, hr, mi, se;

  logic [15:0] ts_year;
  logic [7:0]  ts_month, ts_day, ts_hour, ts_min, ts_sec;
  logic [31:0] ts_us;
  logic        ts_valid, pulse_dv, period_dv, ovf;
  logic [32:0] width_us, period_us;

  logic [15:0] ts_year2;
  logic [7:0]  ts_month2, ts_day2, ts_hour2, ts_min2, ts_sec2;
  logic [31:0] ts_us2;
  logic        ts_valid2, pulse_dv2, period_dv2, ovf2;
  logic [32:0] width_us2, period_us2;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int period_cnt = 0;
  int p0, q0;

  pulse_timestamper dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_pulse_in(pulse),
    .i_thunder_packet_dv(dv), .i_thunder_year(yr), .i_thunder_month(mo),
    .i_thunder_day(dy), .i_thunder_hour(hr), .i_thunder_minutes(mi),
    .i_thunder_seconds(se),
    .o_ts_year(ts_year), .o_ts_month(ts_month), .o_ts_day(ts_day),
    .o_ts_hour(ts_hour), .o_ts_minutes(ts_min), .o_ts_seconds(ts_sec),
    .o_ts_us(ts_us), .o_ts_valid(ts_valid), .o_width_us(width_us),
    .o_period_us(period_us), .o_pulse_dv(pulse_dv), .o_period_dv(period_dv),
    .o_overflow(ovf)
  );

  pulse_timestamper #(.c_CLKS_PER_1_US(1), .c_SYNC_STAGES(2), .c_MEAS_BITS(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_pulse_in(pulse2),
    .i_thunder_packet_dv(dv), .i_thunder_year(yr), .i_thunder_month(mo),
    .i_thunder_day(dy), .i_thunder_hour(hr), .i_thunder_minutes(mi),
    .i_thunder_seconds(se),
    .o_ts_year(ts_year2), .o_ts_month(ts_month2), .o_ts_day(ts_day2),
    .o_ts_hour(ts_hour2), .o_ts_minutes(ts_min2), .o_ts_seconds(ts_sec2),
    .o_ts_us(ts_us2), .o_ts_valid(ts_valid2), .o_width_us(width_us2),
    .o_period_us(period_us2), .o_pulse_dv(pulse_dv2), .o_period_dv(period_dv2),
    .o_overflow(ovf2)
  );

  always @(negedge clk) begin
    if (pulse_dv === 1'b1) pulse_cnt++;
    if (period_dv === 1'b1) period_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rearm();
    en = 1'b0; tick(2);
    en = 1'b1; tick(5);
  endtask

  task automatic send_packet(input logic [7:0] sec);
    dv = 1'b1; yr = 16'd2024; mo = 8'd5; dy = 8'd17; hr = 8'd12; mi = 8'd30; se = sec;
    tick(1);
    dv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; pulse = 1'b0; dv = 1'b0; en2 = 1'b0; pulse2 = 1'b0;
    yr = '0; mo = '0; dy = '0; hr = '0; mi = '0; se = '0;
    tick(4);
    checks++; if (ts_year !== 16'd0) begin errors++; $display("FAIL reset_ts_year: got %0d expected 0", ts_year); end
    checks++; if (ts_us !== 32'd0) begin errors++; $display("FAIL reset_ts_us: got %0d expected 0", ts_us); end
    checks++; if ({ts_valid, pulse_dv, period_dv, ovf} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {ts_valid, pulse_dv, period_dv, ovf}); end
    checks++; if ({width_us, period_us} !== 66'd0) begin errors++; $display("FAIL reset_meas: got %0d/%0d expected 0/0", width_us, period_us); end
    checks++; if ({width_us2, ovf2} !== 34'd0) begin errors++; $display("FAIL reset_sat_dut: got %0d/%b expected 0/0", width_us2, ovf2); end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_timestamp();
    rearm();
    p0 = pulse_cnt; q0 = period_cnt;
    send_packet(8'd45);
    tick(999); pulse = 1'b1;
    tick(250); pulse = 1'b0;
    tick(10);
    checks++; if (ts_us !== 32'd100) begin errors++; $display("FAIL ts_us: got %0d expected 100", ts_us); end
    checks++; if (ts_valid !== 1'b1) begin errors++; $display("FAIL ts_valid: got %b expected 1", ts_valid); end
    checks++; if ({ts_year, ts_month, ts_day} !== {16'd2024, 8'd5, 8'd17}) begin errors++; $display("FAIL ts_date: got %0d/%0d/%0d expected 2024/5/17", ts_year, ts_month, ts_day); end
    checks++; if ({ts_hour, ts_min, ts_sec} !== {8'd12, 8'd30, 8'd45}) begin errors++; $display("FAIL ts_time: got %0d:%0d:%0d expected 12:30:45", ts_hour, ts_min, ts_sec); end
    checks++; if (width_us !== 33'd25) begin errors++; $display("FAIL width: got %0d expected 25", width_us); end
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL pulse_dv_count: got %0d expected 1", pulse_cnt - p0); end
    checks++; if (period_cnt - q0 !== 0) begin errors++; $display("FAIL period_dv_first: got %0d expected 0", period_cnt - q0); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL overflow_normal: got %b expected 0", ovf); end
  endtask

  task automatic test_periodic();
    rearm();
    p0 = pulse_cnt; q0 = period_cnt;
    for (int i = 0; i < 3; i++) begin
      pulse = 1'b1; tick(250);
      pulse = 1'b0; tick(1750);
      if (i == 1) begin
        checks++; if (period_us !== 33'd200) begin errors++; $display("FAIL period_mid: got %0d expected 200", period_us); end
      end
    end
    checks++; if (period_us !== 33'd200) begin errors++; $display("FAIL period_last: got %0d expected 200", period_us); end
    checks++; if (width_us !== 33'd25) begin errors++; $display("FAIL train_width: got %0d expected 25", width_us); end
    checks++; if (period_cnt - q0 !== 2) begin errors++; $display("FAIL period_dv_count: got %0d expected 2", period_cnt - q0); end
    checks++; if (pulse_cnt - p0 !== 3) begin errors++; $display("FAIL train_pulse_count: got %0d expected 3", pulse_cnt - p0); end
  endtask

  task automatic test_already_high();
    en = 1'b0; tick(2);
    pulse = 1'b1; tick(5);
    en = 1'b1; tick(100);
    p0 = pulse_cnt;
    pulse = 1'b0; tick(100);
    checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL early_high_discard: got %0d strobes expected 0", pulse_cnt - p0); end
    pulse = 1'b1; tick(300);
    pulse = 1'b0; tick(20);
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL next_pulse_count: got %0d expected 1", pulse_cnt - p0); end
    checks++; if (width_us !== 33'd30) begin errors++; $display("FAIL next_pulse_width: got %0d expected 30", width_us); end
  endtask

  task automatic test_simultaneous();
    rearm();
    send_packet(8'd45);
    tick(499); pulse = 1'b1;
    tick(2);
    dv = 1'b1; se = 8'd46;
    tick(1); dv = 1'b0;
    tick(247); pulse = 1'b0;
    tick(20);
    checks++; if (ts_sec !== 8'd45) begin errors++; $display("FAIL simul_seconds: got %0d expected 45", ts_sec); end
    checks++; if (ts_us !== 32'd50) begin errors++; $display("FAIL simul_us: got %0d expected 50", ts_us); end
    checks++; if (width_us !== 33'd25) begin errors++; $display("FAIL simul_width: got %0d expected 25", width_us); end
    tick(231); pulse = 1'b1;
    tick(100); pulse = 1'b0;
    tick(20);
    checks++; if (ts_sec !== 8'd46) begin errors++; $display("FAIL after_seconds: got %0d expected 46", ts_sec); end
    checks++; if (ts_us !== 32'd50) begin errors++; $display("FAIL after_us: got %0d expected 50", ts_us); end
    checks++; if (period_us !== 33'd50) begin errors++; $display("FAIL after_period: got %0d expected 50", period_us); end
    checks++; if (width_us !== 33'd10) begin errors++; $display("FAIL after_width: got %0d expected 10", width_us); end
  endtask

  task automatic test_no_packet();
    rearm();
    pulse = 1'b1; tick(100);
    pulse = 1'b0; tick(20);
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL no_packet_valid: got %b expected 0", ts_valid); end
    checks++; if (width_us !== 33'd10) begin errors++; $display("FAIL no_packet_width: got %0d expected 10", width_us); end
  endtask

  task automatic test_enable_drop();
    rearm();
    p0 = pulse_cnt; q0 = period_cnt;
    pulse = 1'b1; tick(50);
    en = 1'b0; tick(5);
    pulse = 1'b0; tick(20);
    checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL drop_no_strobe: got %0d expected 0", pulse_cnt - p0); end
    checks++; if (width_us !== 33'd10) begin errors++; $display("FAIL drop_width_hold: got %0d expected 10", width_us); end
    checks++; if (period_us !== 33'd50) begin errors++; $display("FAIL drop_period_hold: got %0d expected 50", period_us); end
  endtask

  task automatic test_reset_mid();
    rearm();
    p0 = pulse_cnt;
    pulse = 1'b1; tick(50);
    rst = 1'b1; tick(2);
    pulse = 1'b0; rst = 1'b0;
    tick(20);
    checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL rst_no_strobe: got %0d expected 0", pulse_cnt - p0); end
    checks++; if ({width_us, period_us} !== 66'd0) begin errors++; $display("FAIL rst_meas_cleared: got %0d/%0d expected 0/0", width_us, period_us); end
    checks++; if (ts_year !== 16'd0) begin errors++; $display("FAIL rst_ts_cleared: got %0d expected 0", ts_year); end
  endtask

  task automatic test_overflow();
    en2 = 1'b1; tick(5);
    pulse2 = 1'b1; tick(40);
    pulse2 = 1'b0; tick(10);
    checks++; if (width_us2 !== 33'd15) begin errors++; $display("FAIL sat_width: got %0d expected 15", width_us2); end
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b expected 1", ovf2); end
    pulse2 = 1'b1; tick(8);
    pulse2 = 1'b0; tick(10);
    checks++; if (period_us2 !== 33'd15) begin errors++; $display("FAIL sat_period: got %0d expected 15", period_us2); end
    checks++; if (width_us2 !== 33'd8) begin errors++; $display("FAIL short_width: got %0d expected 8", width_us2); end
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL overflow_cleared: got %b expected 0", ovf2); end
  endtask

  initial begin
    test_reset();
    test_timestamp();
    test_periodic();
    test_already_high();
    test_simultaneous();
    test_no_packet();
    test_enable_drop();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_timestamper.md
# pulse_timestamper

Receive-side counterpart of the scheduled pulse generator: measures an external pulse train (typically loop-back of the generator output or a DUT response). For each pulse it timestamps the rising edge against Thunderbolt time (date/time fields plus microseconds since the last Thunderbolt packet) and measures high width and rise-to-rise period in microseconds. Results go to the host/UART reporting path with one-cycle valid strobes.

## Interface
- c_CLKS_PER_1_US, 10, `i_clk` cycles per microsecond.
- c_SYNC_STAGES, 2, synchronizer flops on `i_pulse_in`.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  capture enable; low forces idle.
- `i_pulse_in`  in  1  asynchronous pulse input.
- `i_thunder_packet_dv`  in  1  Thunderbolt time fields valid (one cycle).
- `i_thunder_year`  in  16; `i_thunder_month`, `i_thunder_day`, `i_thunder_hour`, `i_thunder_minutes`, `i_thunder_seconds`  in  8 each.
- `o_ts_year`  out  16; `o_ts_month`, `o_ts_day`, `o_ts_hour`, `o_ts_minutes`, `o_ts_seconds`  out  8 each: time of last captured rise.
- `o_ts_us`  out  32  microseconds since last Thunderbolt packet at that rise.
- `o_ts_valid`  out  1  a Thunderbolt packet had been received since enable when the timestamp was taken.
- `o_width_us`  out  33  high width of last complete pulse.
- `o_period_us`  out  33  last rise-to-rise period.
- `o_pulse_dv`  out  1  one-cycle strobe: timestamp and width updated.
- `o_period_dv`  out  1  one-cycle strobe: period updated.
- `o_overflow`  out  1  a counter saturated during the last reported measurement.

## Operation
- Time shadow: on `i_thunder_packet_dv`, latch all six time fields into internal registers, clear sub-second prescaler and us counter, and set `time_seen`. The us counter increments once per c_CLKS_PER_1_US clocks and saturates at 2^32-1.
- Input path: c_SYNC_STAGES flops, then one edge-detect register. rise = sync & ~prev; fall = ~sync & prev.
- FSM states:
  - s_IDLE -> s_ARM when `i_enable`.
  - s_ARM -> s_WAIT_RISE when the synced input is low. This discards a pulse already high at enable.
  - s_WAIT_RISE -> s_HIGH on rise: latch the timestamp from the shadow registers, `o_ts_us` and `o_ts_valid`; clear the measurement prescaler and both counters.
  - s_HIGH -> s_LOW on fall: `o_width_us` <= width counter; `o_overflow` <= width saturated; pulse `o_pulse_dv`.
  - s_LOW -> s_HIGH on rise: `o_period_us` <= period counter; `o_period_dv` pulses; capture a new timestamp and clear counters, as in s_WAIT_RISE.
- Counters: one prescaler (0..c_CLKS_PER_1_US-1), cleared at each captured rise.
  - Width counter increments in s_HIGH; period counter increments in s_HIGH and s_LOW.
  - Result = floor(clocks/c_CLKS_PER_1_US).
  - Saturate at 2^33-1 and set an internal overflow bit.
- Simultaneous packet dv and rise: the timestamp uses the pre-update shadow and us count; the packet takes effect the next cycle.
- `i_enable` low, from any state: next state s_IDLE; counters cleared. Result outputs hold their last values; strobes are 0. `time_seen` is cleared.

## Timing
- Reset: every output 0, state s_IDLE, shadow registers 0, `time_seen` 0.
- Input edge to detection: c_SYNC_STAGES+1 clocks (3 by default).
- Result registers and strobes update on the clock edge after the detection cycle. They are therefore valid with the strobe, 4 clocks after the pin edge.
- Strobes are exactly one cycle and never assert in s_IDLE or s_ARM.
- A pulse shorter than c_SYNC_STAGES+1 clocks may be missed. No error is flagged.
- Reset mid-measurement takes priority over everything: no strobe is generated.

## Structure
- Package `clockmaster_pkg`: state encodings (4-bit, s_IDLE..s_LOW) and c_CLKS_PER_1_US, shared with the pulse generator.
- Sub-module `bit_synchronizer` (parameter stages, output synced bit) is reused for other asynchronous inputs.
- Everything else is in one module: shadow registers, sub-second counter, FSM, measurement counters.

## Test plan
- Packet dv with 2024/05/17 12:30:45, then 1000 clocks later raise input for 250 clocks -> `o_ts_us`=100, `o_ts_valid`=1, fields match, `o_width_us`=25, one `o_pulse_dv`.
- Periodic 250-high/2000-period clock train, 3 pulses -> `o_period_dv` twice, `o_period_us`=200 each, `o_width_us`=25.
- Input already high at enable -> no capture until the next full pulse; that pulse is measured correctly.
- Rise in the same cycle as packet dv (new seconds=46) -> timestamp seconds=45, `o_ts_us` = old count. Next capture shows 46.
- No packet since enable -> `o_ts_valid`=0. `i_enable` dropped mid-high -> no strobe; outputs hold. `i_rst` mid-high -> all outputs 0.
- Force the width counter near 2^33-1 (shortened parameter build) -> width saturates, `o_overflow`=1.
